// File: rtl/led_cmd_sched.sv
// led_cmd_sched
//   Sequences timed colour/brightness commands for the two RGB_LED channels of
//   the reaction-time tester. Each channel runs off / solid / blink, either for a
//   number of prescaled ticks or indefinitely, and owns one pending slot so a
//   follow-up pattern can be queued behind a timed command.
//
//   Optional build macro: LED_BLINK_SYNC_EN
//     defined   - one shared free-running blink phase, both LEDs blink in unison
//     undefined - each channel restarts its own blink phase (ON) on every load
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready is combinational)
//   cmd_ch               target channel (0 = LED1, 1 = LED2)
//   cmd_mode             00 off, 01 solid, 10 blink, 11 off
//   cmd_color/cmd_bright RGB bits / brightness (0 half, 1 full)
//   cmd_dur              duration in ticks, 0 = indefinite
//   abort[1:0]           per-channel clear, bit0 = LED1
//   color1/2, bright1/2  registered drive to RGB_LED
//   busy[1:0]            channel running a timed command
//   done[1:0]            one-cycle pulse when a timed command expires
module led_cmd_sched #(
   parameter int TICK_DIV   = 50000,
   parameter int BLINK_HALF = 250,
   parameter int DUR_W      = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_ch,
   input  logic [1:0]       cmd_mode,
   input  logic [2:0]       cmd_color,
   input  logic             cmd_bright,
   input  logic [DUR_W-1:0] cmd_dur,
   input  logic [1:0]       abort,
   output logic [2:0]       color1,
   output logic [2:0]       color2,
   output logic             bright1,
   output logic             bright2,
   output logic [1:0]       busy,
   output logic [1:0]       done
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam int PH_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   typedef enum logic [1:0] {ST_OFF, ST_SOLID, ST_BLK_ON, ST_BLK_OFF} state_e;

   logic [CNT_W-1:0] pre_q, pre_d;
   logic             tick;

   state_e           state_q [2], state_d [2];
   logic [2:0]       col_q   [2], col_d   [2];
   logic [2:0]       color_q [2], color_d [2];
   logic [DUR_W-1:0] dur_q   [2], dur_d   [2];
   logic [1:0]       pmode_q [2], pmode_d [2];
   logic [2:0]       pcol_q  [2], pcol_d  [2];
   logic [DUR_W-1:0] pdur_q  [2], pdur_d  [2];
   logic [1:0]       brt_q, brt_d, timed_q, timed_d, pend_v_q, pend_v_d;
   logic [1:0]       pbrt_q, pbrt_d, done_q, done_d;
   logic [1:0]       xfer, expire;
   logic             blink_on;

   // Staging for whichever command (pending slot or incoming) gets loaded.
   logic             do_load, ld_brt;
   logic [1:0]       ld_mode;
   logic [2:0]       ld_col;
   logic [DUR_W-1:0] ld_dur;

`ifdef LED_BLINK_SYNC_EN
   logic [PH_W-1:0]  sh_ph_q, sh_ph_d;
   logic             sh_on_q, sh_on_d;
`else
   logic [PH_W-1:0]  ph_q [2], ph_d [2];
`endif

   function automatic state_e mode_state(input logic [1:0] mode, input logic on);
      case (mode)
         2'b01:   return ST_SOLID;
         2'b10:   return on ? ST_BLK_ON : ST_BLK_OFF;
         default: return ST_OFF;
      endcase
   endfunction

   assign tick      = (pre_q == CNT_W'(TICK_DIV - 1));
   assign cmd_ready = ~pend_v_q[cmd_ch] & ~abort[cmd_ch];
   assign color1    = color_q[0];
   assign color2    = color_q[1];
   assign bright1   = brt_q[0];
   assign bright2   = brt_q[1];
   assign busy      = timed_q;
   assign done      = done_q;

   always_comb begin
      pre_d    = tick ? '0 : pre_q + 1'b1;
      brt_d    = brt_q;
      timed_d  = timed_q;
      pend_v_d = pend_v_q;
      pbrt_d   = pbrt_q;
      done_d   = '0;
      xfer     = '0;
      expire   = '0;
      do_load  = 1'b0;
      ld_mode  = '0;
      ld_col   = '0;
      ld_brt   = 1'b0;
      ld_dur   = '0;
`ifdef LED_BLINK_SYNC_EN
      sh_ph_d = sh_ph_q;
      sh_on_d = sh_on_q;
      if (tick) begin
         if (sh_ph_q == PH_W'(BLINK_HALF - 1)) begin
            sh_ph_d = '0;
            sh_on_d = ~sh_on_q;
         end else begin
            sh_ph_d = sh_ph_q + 1'b1;
         end
      end
      // Next-cycle shared phase so a fresh load lines up with the other channel.
      blink_on = sh_on_d;
`else
      blink_on = 1'b1;
`endif
      for (int n = 0; n < 2; n++) begin
         state_d[n] = state_q[n];
         col_d[n]   = col_q[n];
         dur_d[n]   = dur_q[n];
         pmode_d[n] = pmode_q[n];
         pcol_d[n]  = pcol_q[n];
         pdur_d[n]  = pdur_q[n];
         do_load    = 1'b0;
         ld_mode    = cmd_mode;
         ld_col     = cmd_color;
         ld_brt     = cmd_bright;
         ld_dur     = cmd_dur;
         xfer[n]    = cmd_valid & cmd_ready & (cmd_ch == 1'(n));
         expire[n]  = timed_q[n] & tick & (dur_q[n] == DUR_W'(1));

         // Blink progression.
`ifdef LED_BLINK_SYNC_EN
         if (state_q[n] == ST_BLK_ON || state_q[n] == ST_BLK_OFF)
            state_d[n] = sh_on_d ? ST_BLK_ON : ST_BLK_OFF;
`else
         ph_d[n] = ph_q[n];
         if (tick && (state_q[n] == ST_BLK_ON || state_q[n] == ST_BLK_OFF)) begin
            if (ph_q[n] == PH_W'(BLINK_HALF - 1)) begin
               ph_d[n]    = '0;
               state_d[n] = (state_q[n] == ST_BLK_ON) ? ST_BLK_OFF : ST_BLK_ON;
            end else begin
               ph_d[n] = ph_q[n] + 1'b1;
            end
         end
`endif
         if (timed_q[n] && tick)
            dur_d[n] = dur_q[n] - 1'b1;

         if (expire[n]) begin
            timed_d[n] = 1'b0;
            state_d[n] = ST_OFF;
            done_d[n]  = 1'b1;
            if (pend_v_q[n]) begin
               // Pending slot takes over on the same edge: no OFF gap.
               pend_v_d[n] = 1'b0;
               do_load     = 1'b1;
               ld_mode     = pmode_q[n];
               ld_col      = pcol_q[n];
               ld_brt      = pbrt_q[n];
               ld_dur      = pdur_q[n];
            end else begin
               do_load = xfer[n];
            end
         end else if (xfer[n]) begin
            if (timed_q[n]) begin
               pend_v_d[n] = 1'b1;
               pmode_d[n]  = cmd_mode;
               pcol_d[n]   = cmd_color;
               pbrt_d[n]   = cmd_bright;
               pdur_d[n]   = cmd_dur;
            end else begin
               do_load = 1'b1;   // idle or untimed: pre-empt
            end
         end

         if (do_load) begin
            state_d[n] = mode_state(ld_mode, blink_on);
            col_d[n]   = ld_col;
            brt_d[n]   = ld_brt;
            dur_d[n]   = ld_dur;
            timed_d[n] = (ld_dur != '0);
`ifndef LED_BLINK_SYNC_EN
            ph_d[n] = '0;
`endif
         end

         // Abort beats everything, including a same-cycle expiry.
         if (abort[n]) begin
            state_d[n]  = ST_OFF;
            col_d[n]    = '0;
            brt_d[n]    = 1'b0;
            dur_d[n]    = '0;
            timed_d[n]  = 1'b0;
            pend_v_d[n] = 1'b0;
            done_d[n]   = 1'b0;
`ifndef LED_BLINK_SYNC_EN
            ph_d[n] = '0;
`endif
         end

         color_d[n] = (state_d[n] == ST_SOLID || state_d[n] == ST_BLK_ON) ? col_d[n] : 3'b000;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pre_q    <= '0;
         brt_q    <= '0;
         timed_q  <= '0;
         pend_v_q <= '0;
         pbrt_q   <= '0;
         done_q   <= '0;
         for (int n = 0; n < 2; n++) begin
            state_q[n] <= ST_OFF;
            col_q[n]   <= '0;
            color_q[n] <= '0;
            dur_q[n]   <= '0;
            pmode_q[n] <= '0;
            pcol_q[n]  <= '0;
            pdur_q[n]  <= '0;
`ifndef LED_BLINK_SYNC_EN
            ph_q[n] <= '0;
`endif
         end
`ifdef LED_BLINK_SYNC_EN
         sh_ph_q <= '0;
         sh_on_q <= 1'b1;
`endif
      end else begin
         pre_q    <= pre_d;
         brt_q    <= brt_d;
         timed_q  <= timed_d;
         pend_v_q <= pend_v_d;
         pbrt_q   <= pbrt_d;
         done_q   <= done_d;
         for (int n = 0; n < 2; n++) begin
            state_q[n] <= state_d[n];
            col_q[n]   <= col_d[n];
            color_q[n] <= color_d[n];
            dur_q[n]   <= dur_d[n];
            pmode_q[n] <= pmode_d[n];
            pcol_q[n]  <= pcol_d[n];
            pdur_q[n]  <= pdur_d[n];
`ifndef LED_BLINK_SYNC_EN
            ph_q[n] <= ph_d[n];
`endif
         end
`ifdef LED_BLINK_SYNC_EN
         sh_ph_q <= sh_ph_d;
         sh_on_q <= sh_on_d;
`endif
      end
   end

endmodule
